fft_out_serializer: RTL and testbench
=====================================

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter DW, default 16: width of each real/imaginary component; SHALL be fixed at 16 for this release.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  one-cycle frame-ready strobe from the FFT core.
REQ-005 Y_0..Y_15  input  32 each  FFT bins: [31:16] real, [15:0] imaginary, two's complement.
REQ-006 out_ready  input  1  downstream accepts the current beat.
REQ-007 out_valid  output  1  current beat is valid.
REQ-008 out_re, out_im  output  16 each  real and imaginary parts of the current bin.
REQ-009 out_mag  output  32  unsigned out_re^2 + out_im^2.
REQ-010 out_idx  output  4  bin index of the current beat.
REQ-011 out_last  output  1  high on the beat carrying bin 15.
REQ-012 busy  output  1  high while a frame is held or streaming.
REQ-013 overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-014 The block SHALL use two states: IDLE and STREAM.
REQ-015 In IDLE, load=1 at a rising edge SHALL capture all 16 Y inputs into a 16x32 buffer, set idx=0, and enter STREAM.
REQ-016 out_valid SHALL be 1 in the first cycle after the capturing edge, giving one cycle of latency.
REQ-017 out_valid SHALL equal (state==STREAM); busy SHALL equal out_valid.
REQ-018 out_re, out_im, out_idx and out_mag SHALL be derived only from registered buffer[idx] and idx.
REQ-019 These outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 A transfer SHALL occur only at an edge where out_valid=1 and out_ready=1; each transfer SHALL increment idx by 1.
REQ-021 out_last SHALL equal out_valid AND (idx==15).
REQ-022 On the transfer of bin 15, idx SHALL wrap to 0 and the state SHALL return to IDLE, unless REQ-023 applies.
REQ-023 If load=1 in the same cycle as the bin-15 transfer, the new frame SHALL be captured, idx SHALL be 0, and the state SHALL remain STREAM.
- Back-to-back frames SHALL therefore have no bubble.
- overrun SHALL NOT be set in this case.
REQ-024 load=1 in STREAM at any other time SHALL be ignored:
- buffer and idx SHALL be unchanged;
- overrun SHALL be set to 1 and held until reset.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 out_mag SHALL be computed as sign-extended squares summed unsigned, with no overflow.
- Maximum value is 2^31, for re = im = -32768.
REQ-027 load held high for multiple cycles in IDLE SHALL capture on the first edge only; subsequent cycles follow REQ-024.

Reset
REQ-028 RST=0 SHALL immediately force:
- state IDLE, idx=0, and every buffer entry 0;
- out_valid, out_last, busy, overrun = 0;
- out_re, out_im, out_mag, out_idx = 0.
REQ-029 Reset asserted mid-stream SHALL abandon the frame; no beat SHALL be emitted after reset release until a new load.
REQ-030 load=1 in the first edge after RST deasserts SHALL be captured normally.

Verification
REQ-031 Basic frame:
- Stimulus: Y_k = {k, -k} for k = 0..15; load pulse; out_ready=1 throughout.
- Response: 16 consecutive beats with idx 0..15, out_re=k, out_im=-k, out_mag=2k^2, out_last on beat 15 only; then out_valid=0.
REQ-032 Backpressure:
- Stimulus: out_ready toggled 1,0,0,1,...
- Response: beats are held stable while out_ready=0; all 16 beats are delivered in order with no duplicates.
REQ-033 Extreme magnitude:
- Stimulus: Y_3 = 32'h8000_8000.
- Response: beat 3 shows out_re = out_im = -32768 and out_mag = 32'h8000_0000.
REQ-034 Overrun:
- Stimulus: load pulsed during beat 5 of a frame.
- Response: overrun=1; remaining beats still come from the original frame; overrun stays 1 through later frames.
REQ-035 Back-to-back:
- Stimulus: load coincident with the bin-15 transfer, second frame Y_k = {100+k, 0}.
- Response: out_valid stays 1; the next beat is idx 0 with out_re=100; overrun=0.
REQ-036 Async reset:
- Stimulus: RST low between edges at beat 7.
- Response: all outputs 0 immediately; no valid beats until the next load.

Source files
------------

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - captures a 16-bin FFT frame and streams it out one bin per beat
// Two-state serializer with registered frame buffer, sticky overrun and per-bin magnitude.
module fft_out_serializer #(
  parameter int DW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            load,
  input  logic [2*DW-1:0] Y_0,
  input  logic [2*DW-1:0] Y_1,
  input  logic [2*DW-1:0] Y_2,
  input  logic [2*DW-1:0] Y_3,
  input  logic [2*DW-1:0] Y_4,
  input  logic [2*DW-1:0] Y_5,
  input  logic [2*DW-1:0] Y_6,
  input  logic [2*DW-1:0] Y_7,
  input  logic [2*DW-1:0] Y_8,
  input  logic [2*DW-1:0] Y_9,
  input  logic [2*DW-1:0] Y_10,
  input  logic [2*DW-1:0] Y_11,
  input  logic [2*DW-1:0] Y_12,
  input  logic [2*DW-1:0] Y_13,
  input  logic [2*DW-1:0] Y_14,
  input  logic [2*DW-1:0] Y_15,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [2*DW-1:0] out_mag,
  output logic [3:0]      out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q;
  logic [2*DW-1:0] buf_q [16];
  logic [2*DW-1:0] y_in  [16];
  logic            xfer, capture, drop;

  assign y_in[0]  = Y_0;
  assign y_in[1]  = Y_1;
  assign y_in[2]  = Y_2;
  assign y_in[3]  = Y_3;
  assign y_in[4]  = Y_4;
  assign y_in[5]  = Y_5;
  assign y_in[6]  = Y_6;
  assign y_in[7]  = Y_7;
  assign y_in[8]  = Y_8;
  assign y_in[9]  = Y_9;
  assign y_in[10] = Y_10;
  assign y_in[11] = Y_11;
  assign y_in[12] = Y_12;
  assign y_in[13] = Y_13;
  assign y_in[14] = Y_14;
  assign y_in[15] = Y_15;

  assign xfer = (state_q == STREAM) && out_ready;

  // A load coinciding with the final transfer chains the next frame with no bubble.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && (idx_q == 4'd15)) begin
          if (load) capture = 1'b1;
          else      state_d = IDLE;
        end else if (load) begin
          drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      overrun <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (drop) overrun <= 1'b1;
      if (capture) begin
        idx_q <= 4'd0;
        for (int i = 0; i < 16; i++) buf_q[i] <= y_in[i];
      end else if (xfer) begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  logic [2*DW-1:0]        cur;
  logic signed [2*DW-1:0] re_x, im_x;
  logic [2*DW-1:0]        re_sq, im_sq;

  assign cur    = buf_q[idx_q];
  assign out_re = cur[2*DW-1:DW];
  assign out_im = cur[DW-1:0];
  // Squares of sign-extended components are non-negative and at most 2^30 each.
  assign re_x   = {{DW{out_re[DW-1]}}, out_re};
  assign im_x   = {{DW{out_im[DW-1]}}, out_im};
  assign re_sq  = re_x * re_x;
  assign im_sq  = im_x * im_x;
  assign out_mag = re_sq + im_sq;

  assign out_idx   = idx_q;
  assign out_valid = (state_q == STREAM);
  assign busy      = out_valid;
  assign out_last  = out_valid && (idx_q == 4'd15);

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - randomized directed bench for fft_out_serializer
// Expected beats come from a queue-based scoreboard of captured frames.
module tb_fft_out_serializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        load = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] y [16];
  logic        out_valid, out_last, busy, overrun;
  logic [15:0] out_re, out_im;
  logic [31:0] out_mag;
  logic [3:0]  out_idx;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [31:0] mag;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  beat_t q[$];
  logic  ov_exp = 1'b0;
  int    tests = 0;
  int    fails = 0;

  always #5 CLK = ~CLK;

  fft_out_serializer #(.DW(16)) dut (
    .CLK(CLK), .RST(RST), .load(load),
    .Y_0(y[0]), .Y_1(y[1]), .Y_2(y[2]), .Y_3(y[3]),
    .Y_4(y[4]), .Y_5(y[5]), .Y_6(y[6]), .Y_7(y[7]),
    .Y_8(y[8]), .Y_9(y[9]), .Y_10(y[10]), .Y_11(y[11]),
    .Y_12(y[12]), .Y_13(y[13]), .Y_14(y[14]), .Y_15(y[15]),
    .out_ready(out_ready), .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_mag(out_mag), .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) y[k] = $urandom;
  endtask

  task automatic push_frame();
    for (int k = 0; k < 16; k++) begin
      beat_t b;
      longint r, i, m;
      b.re = y[k][31:16];
      b.im = y[k][15:0];
      r = longint'($signed(b.re));
      i = longint'($signed(b.im));
      m = r * r + i * i;
      b.mag  = m[31:0];
      b.idx  = 4'(k);
      b.last = (k == 15);
      q.push_back(b);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
    chk("overrun", {31'd0, overrun}, {31'd0, ov_exp});
    if (q.size() != 0) begin
      chk("out_idx", {28'd0, out_idx}, {28'd0, q[0].idx});
      chk("out_re", {16'd0, out_re}, {16'd0, q[0].re});
      chk("out_im", {16'd0, out_im}, {16'd0, q[0].im});
      chk("out_mag", out_mag, q[0].mag);
      chk("out_last", {31'd0, out_last}, {31'd0, q[0].last});
    end else begin
      chk("out_last_idle", {31'd0, out_last}, 32'd0);
    end
  endtask

  // Apply inputs for the next rising edge, advance the model, then check at the falling edge.
  task automatic step(input logic ld, input logic rdy);
    logic accept;
    load = ld;
    out_ready = rdy;
    accept = ld && (q.size() == 0 || (q.size() == 1 && rdy));
    if (ld && !accept) ov_exp = 1'b1;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (accept) push_frame();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic drain(input int pattern);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      logic r;
      case (pattern)
        0: r = 1'b1;
        1: r = (n % 3) == 0;
        default: r = 1'(($urandom % 2));
      endcase
      step(1'b0, r);
      n++;
    end
    chk("drain_done", q.size(), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_re"}, {16'd0, out_re}, 32'd0);
    chk({tag, "_im"}, {16'd0, out_im}, 32'd0);
    chk({tag, "_mag"}, out_mag, 32'd0);
    chk({tag, "_idx"}, {28'd0, out_idx}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) y[k] = '0;
    #12;
    check_zero("reset");
    @(negedge CLK);
    RST = 1'b1;

    // Basic frame: {k, -k}
    for (int k = 0; k < 16; k++) y[k] = {16'(k), 16'(-k)};
    step(1'b1, 1'b1);
    drain(0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Backpressure with 1,0,0 pattern
    rand_frame();
    step(1'b1, 1'b0);
    drain(1);

    // Extreme magnitude at bin 3
    rand_frame();
    y[3] = 32'h8000_8000;
    step(1'b1, 1'b1);
    drain(2);

    // Back-to-back: load coincident with bin-15 transfer
    rand_frame();
    step(1'b1, 1'b1);
    while (q.size() > 1) step(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) y[k] = {16'(100 + k), 16'd0};
    step(1'b1, 1'b1);
    chk("b2b_re", {16'd0, out_re}, 32'd100);
    chk("b2b_overrun", {31'd0, overrun}, 32'd0);
    drain(2);

    // Overrun: load during beat 5, new data must be ignored
    rand_frame();
    step(1'b1, 1'b1);
    while (q[0].idx != 4'd5) step(1'b0, 1'b1);
    rand_frame();
    step(1'b1, 1'b0);
    drain(0);
    rand_frame();
    step(1'b1, 1'b1);
    drain(2);

    // Load held high for several cycles in IDLE
    rand_frame();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    drain(0);

    // Async reset between edges at beat 7
    rand_frame();
    step(1'b1, 1'b1);
    while (q[0].idx != 4'd7) step(1'b0, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete();
    ov_exp = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1);

    // Capture right after reset release
    #2;
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    rand_frame();
    step(1'b1, 1'b1);
    drain(2);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom % 8 == 0) rand_frame();
      step(1'($urandom % 16 == 0), 1'($urandom % 4 != 0));
    end
    drain(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
